// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and fills the IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN turns a misaligned PC into an address-misaligned fetch exception.
module fetch_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  input  logic            imem_exc_en,
  input  logic [3:0]      imem_exc_code,
  input  logic [XLEN-1:0] imem_exc_val,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_exc_en,
  output logic [3:0]      if_exc_code,
  output logic [XLEN-1:0] if_exc_val,
  output logic [63:0]     fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            if_valid_reg;
  logic [XLEN-1:0] if_pc_reg;
  logic [31:0]     if_instr_reg;
  logic            if_exc_en_reg;
  logic [3:0]      if_exc_code_reg;
  logic [XLEN-1:0] if_exc_val_reg;
  logic [63:0]     fetch_count_reg;

  logic load;
  logic misaligned;

  assign load = (state_reg == RUN) && (!if_valid_reg || id_ready);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = |pc_reg[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      if_valid_reg    <= 1'b0;
      if_pc_reg       <= '0;
      if_instr_reg    <= NOP_INSTR;
      if_exc_en_reg   <= 1'b0;
      if_exc_code_reg <= 4'd0;
      if_exc_val_reg  <= '0;
      fetch_count_reg <= 64'd0;
    end else begin
      // A handoff is counted even when a redirect flushes the stage in the same cycle.
      if (if_valid_reg && id_ready)
        fetch_count_reg <= fetch_count_reg + 64'd1;

      if (redirect_valid) begin
        pc_reg       <= redirect_pc;
        if_valid_reg <= 1'b0;
        state_reg    <= RUN;
      end else if (load) begin
        if_valid_reg <= 1'b1;
        if_pc_reg    <= pc_reg;
        if (misaligned) begin
          if_instr_reg    <= NOP_INSTR;
          if_exc_en_reg   <= 1'b1;
          if_exc_code_reg <= 4'd0;
          if_exc_val_reg  <= pc_reg;
          state_reg       <= HALT;
        end else if (imem_exc_en) begin
          if_instr_reg    <= NOP_INSTR;
          if_exc_en_reg   <= 1'b1;
          if_exc_code_reg <= imem_exc_code;
          if_exc_val_reg  <= imem_exc_val;
          state_reg       <= HALT;
        end else begin
          if_instr_reg    <= imem_instr;
          if_exc_en_reg   <= 1'b0;
          if_exc_code_reg <= 4'd0;
          if_exc_val_reg  <= '0;
          pc_reg          <= pc_reg + XLEN'(4);
        end
      end else if (if_valid_reg && id_ready) begin
        // Only reachable in HALT: the exception entry leaves and the stage goes idle.
        if_valid_reg <= 1'b0;
      end
    end
  end

  assign imem_pc     = pc_reg;
  assign if_valid    = if_valid_reg;
  assign if_pc       = if_pc_reg;
  assign if_instr    = if_instr_reg;
  assign if_exc_en   = if_exc_en_reg;
  assign if_exc_code = if_exc_code_reg;
  assign if_exc_val  = if_exc_val_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV64 core, directly upstream of the instruction memory.
- Owns the program counter and drives the combinational instruction memory with the PC each cycle.
- Registers the returned instruction word and any fetch exception into the IF/ID pipeline register, with a valid/ready handshake toward decode.
- Handles redirects (branch, jump, trap, mret) and holds fetch after an instruction access fault until a redirect arrives.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word presented when no valid instruction is held.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_pc  output  XLEN  fetch address to instruction memory; equals the internal PC register.
- imem_instr  input  32  instruction word from memory (combinational response to imem_pc).
- imem_exc_en  input  1  memory reports a fetch exception for imem_pc.
- imem_exc_code  input  4  exception cause from memory.
- imem_exc_val  input  XLEN  faulting address from memory.
- redirect_valid  input  1  load a new PC and flush this stage.
- redirect_pc  input  XLEN  redirect target.
- id_ready  input  1  decode accepts the IF/ID register this cycle.
- if_valid  output  1  IF/ID register holds a valid entry.
- if_pc  output  XLEN  PC of the held entry.
- if_instr  output  32  held instruction; NOP_INSTR when the entry is an exception.
- if_exc_en  output  1  held entry carries a fetch exception.
- if_exc_code  output  4  cause of the held exception.
- if_exc_val  output  XLEN  tval of the held exception.
- fetch_count  output  64  number of entries handed to decode (if_valid && id_ready).

Behaviour:
- Reset values:
  - pc = RESET_PC, state = RUN.
  - if_valid = 0, if_pc = 0, if_instr = NOP_INSTR.
  - if_exc_en = 0, if_exc_code = 0, if_exc_val = 0, fetch_count = 0.
  - Memory outputs are ignored while rst is high.
- Define load = (state == RUN) && (!if_valid || id_ready).
- States:
  - RUN: normal fetching.
  - HALT: an exception entry has been issued; the PC is frozen and no new loads occur.
- Priority per cycle: rst > redirect_valid > load > hold.
- Redirect (redirect_valid = 1):
  - pc <= redirect_pc; if_valid <= 0 (flush, even if decode is stalled); state <= RUN.
  - The memory response in that cycle is discarded.
  - fetch_count still increments if if_valid && id_ready held in that same cycle.
- Load with imem_exc_en = 0:
  - IF/ID register <= {pc, imem_instr, exc 0}; if_valid <= 1.
  - pc <= pc + 4, wrapping modulo 2^XLEN (no fault on wrap).
- Load with imem_exc_en = 1:
  - IF/ID register <= {pc, NOP_INSTR, 1, imem_exc_code, imem_exc_val}; if_valid <= 1.
  - pc is held; state <= HALT.
  - The memory's later deasserted exc_en is ignored while in HALT.
- Stall (if_valid && !id_ready, no redirect): all IF/ID fields and pc are held stable.
- In HALT: once the exception entry is accepted, if_valid <= 0. The stage stays idle until a redirect.
- Latency: fetch address to if_valid is 1 cycle. Sustained throughput is 1 instruction per cycle when id_ready = 1.
- fetch_count increments by 1 on every cycle with if_valid && id_ready, and wraps at 2^64.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - If redirect_pc[1:0] != 0, the redirect still loads pc and flushes.
  - The next load does not use memory data. It issues an exception entry with code 4'd0 (instruction address misaligned), if_exc_val = pc, and if_instr = NOP_INSTR; state <= HALT.
- Undefined:
  - pc[1:0] is passed to memory unchanged. Memory indexes by pc[17:2], so the low bits are effectively truncated.

Test Plan:
- Reset, then id_ready = 1 with memory words 0x00500093, 0x00108113 → if_pc 0x0 then 0x4 on consecutive cycles; if_instr matches; fetch_count = 2 after 2 cycles.
- Hold id_ready = 0 for 3 cycles after the first entry → if_pc stays 0x0, imem_pc stays 0x4; entry 0x4 follows the cycle after release.
- redirect_valid with redirect_pc = 0x100 during a stall → if_valid = 0 next cycle; imem_pc = 0x100; the next entry is at if_pc 0x100.
- Memory returns exc_en = 1, code 1, val 0x2000 at pc 0x2000 → entry with if_exc_en = 1, code 1, val 0x2000, if_instr 0x13; pc frozen; if_valid = 0 after accept until redirect to 0x80.
- Redirect and exception in the same cycle → redirect wins; state RUN; no exception entry.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → exception entry with code 0 and val 0x102; without the macro, the entry at 0x102 carries the instruction stored at word index 0x40.
